fila_circular: RTL and testbench
================================

// Module: fila_circular
// PURPOSE
//  Parametrised circular-buffer FIFO; next generation of the 8x8 shift queue.
//  - Generic WIDTH/DEPTH; read/write pointers replace the shift register.
//  - Single-cycle enqueue/dequeue; simultaneous enqueue+dequeue accepted.
//  - Status: full/empty, overflow/underflow, synchronous clear.
//  - Sits between the input producer and the display/consumer logic on clock_10khz.
// PARAMETERS
//  WIDTH   8                 data word width in bits (>=1)
//  DEPTH   8                 number of entries (>=2, need not be a power of two)
//  LEN_W   $clog2(DEPTH+1)   width of len_out; derived, do not override
// PORTS
//  clock_10khz     in   1      single system clock, rising edge
//  reset           in   1      asynchronous, active-low (0 = reset)
//  clear_in        in   1      synchronous flush; priority over enqueue/dequeue
//  data_in         in   WIDTH  word to enqueue
//  enqueue_in      in   1      enqueue request, sampled every edge
//  dequeue_in      in   1      dequeue request, sampled every edge
//  data_out        out  WIDTH  last dequeued word (registered)
//  data_valid_out  out  1      1-cycle pulse: data_out updated this cycle
//  len_out         out  LEN_W  current occupancy, 0..DEPTH
//  full_out        out  1      len_out == DEPTH
//  empty_out       out  1      len_out == 0
//  overflow_out    out  1      1-cycle pulse: enqueue rejected (full)
//  underflow_out   out  1      1-cycle pulse: dequeue rejected (empty)
// BEHAVIOUR
//  - Reset (reset=0, async): wr_ptr=rd_ptr=0, len=0, data_out=0, all pulses 0;
//    memory contents are don't-care. Reset mid-operation aborts any op.
//  - Op decode per edge, from pre-edge state (op_t):
//    enq_ok = enqueue_in & (!full | dequeue_in); deq_ok = dequeue_in & !empty.
//  - enq_ok: mem[wr_ptr] <= data_in; wr_ptr advances.
//  - deq_ok: data_out <= mem[rd_ptr]; rd_ptr advances; data_valid_out=1 next cycle.
//  - len: +1 enq only, -1 deq only, unchanged on both or neither.
//  - Pointer wrap: ptr == DEPTH-1 -> 0, else ptr+1.
//    No power-of-two arithmetic is assumed.
//  - Full + enqueue + dequeue: both accepted, len stays DEPTH, no overflow.
//  - Empty + enqueue + dequeue: enqueue accepted, dequeue rejected,
//    underflow_out=1, len -> 1. No fall-through bypass.
//  - Full + enqueue only: overflow_out=1; memory and pointers unchanged.
//  - Empty + dequeue only: underflow_out=1; data_out holds.
//  - clear_in=1: pointers and len -> 0 next edge. data_out holds.
//    No pulses are raised that cycle.
//  - data_out holds its value between dequeues. Latency request -> data_out: 1 edge.
//  - full_out/empty_out/len_out are registered-state derived; no combinational
//    paths from inputs to outputs.
// STRUCTURE
//  - fila_pkg: typedef enum logic [1:0] op_t {OP_NONE, OP_ENQ, OP_DEQ, OP_BOTH};
//    function next_ptr(ptr, depth) for the wrap rule.
//  - Sub-module fila_ptr #(DEPTH): wrapping pointer register with advance and
//    clear inputs; instantiated twice (write and read).
//  - Top level: op decode, len counter, storage array, output registers.
// TESTING
//  1. Reset, then 3 enqueues (0xA1,0xB2,0xC3), then 3 dequeues ->
//     data_out A1,B2,C3, each with a valid pulse; len 3->0; empty_out=1.
//  2. 8 enqueues (DEPTH=8) -> full_out=1, len=8. 9th enqueue -> overflow pulse,
//     len stays 8; later dequeues return the first 8 words in order.
//  3. Full + enqueue 0x55 + dequeue -> oldest word out, len stays 8, no overflow.
//     After wrap, the 8th later dequeue returns 0x55.
//  4. Empty + enqueue 0x77 + dequeue -> underflow pulse, len=1. Next dequeue -> 0x77.
//  5. DEPTH=5, 12 enqueue/dequeue pairs -> pointers wrap 0..4 correctly;
//     data order is preserved.
//  6. len=4, drive clear_in -> len=0, empty_out=1.
//     Reset pulsed mid-burst -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/fila_pkg.sv
// fila_pkg: shared operation encoding and pointer wrap rule for the circular FIFO.
package fila_pkg;

    typedef enum logic [1:0] {OP_NONE, OP_ENQ, OP_DEQ, OP_BOTH} op_t;

    // Explicit compare-and-reset so DEPTH need not be a power of two
    function automatic int next_ptr(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fila_ptr.sv
// fila_ptr: wrapping pointer register over 0..DEPTH-1 with advance and synchronous clear.
module fila_ptr
    import fila_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             adv_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q, ptr_d;

    always_comb ptr_d = clear_i ? '0 : adv_i ? PTR_W'(next_ptr(32'(ptr_q), DEPTH)) : ptr_q;

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) ptr_q <= '0;
        else         ptr_q <= ptr_d;

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fila_circular.sv
// fila_circular: parametrised circular-buffer FIFO with registered data output,
// occupancy count, full/empty status and overflow/underflow pulses.
module fila_circular
    import fila_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int LEN_W = $clog2(DEPTH + 1)
) (
    input  logic             clock_10khz,
    input  logic             reset,
    input  logic             clear_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             enqueue_in,
    input  logic             dequeue_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid_out,
    output logic [LEN_W-1:0] len_out,
    output logic             full_out,
    output logic             empty_out,
    output logic             overflow_out,
    output logic             underflow_out
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LEN_W-1:0] len_q, len_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d, ovf_q, ovf_d, unf_q, unf_d;
    logic             full, empty, enq_ok, deq_ok;
    op_t              op;

    assign full  = len_q == LEN_W'(DEPTH);
    assign empty = len_q == '0;

    // Clear suppresses every operation and pulse for its cycle
    assign enq_ok = !clear_in & enqueue_in & (!full | dequeue_in);
    assign deq_ok = !clear_in & dequeue_in & !empty;
    assign op     = op_t'({deq_ok, enq_ok});

    always_comb begin
        len_d   = clear_in ? '0 :
                  op == OP_ENQ ? len_q + LEN_W'(1) :
                  op == OP_DEQ ? len_q - LEN_W'(1) : len_q;
        data_d  = deq_ok ? mem_q[rd_ptr] : data_q;
        valid_d = deq_ok;
        ovf_d   = !clear_in & enqueue_in & full & !dequeue_in;
        unf_d   = !clear_in & dequeue_in & empty;
    end

    fila_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk_i   (clock_10khz),
        .rst_ni  (reset),
        .clear_i (clear_in),
        .adv_i   (enq_ok),
        .ptr_o   (wr_ptr)
    );

    fila_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk_i   (clock_10khz),
        .rst_ni  (reset),
        .clear_i (clear_in),
        .adv_i   (deq_ok),
        .ptr_o   (rd_ptr)
    );

    always_ff @(posedge clock_10khz)
        if (enq_ok) mem_q[wr_ptr] <= data_in;

    always_ff @(posedge clock_10khz or negedge reset)
        if (!reset) begin
            len_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            len_q   <= len_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end

    assign data_out       = data_q;
    assign data_valid_out = valid_q;
    assign len_out        = len_q;
    assign full_out       = full;
    assign empty_out      = empty;
    assign overflow_out   = ovf_q;
    assign underflow_out  = unf_q;

endmodule

// File: tb/tb_fila_circular.sv
// tb_fila_circular: directed checks of the circular FIFO at DEPTH=8 and DEPTH=5 sharing one stimulus.
module tb_fila_circular;

    logic       clk = 1'b0, rst_n = 1'b1, clr = 1'b0, enq = 1'b0, deq = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] d8, d5;
    logic       v8, v5, f8, f5, e8, e5, o8, o5, u8, u5;
    logic [3:0] l8;
    logic [2:0] l5;
    int         total = 0, passed = 0;
    logic [7:0] t1 [3] = '{8'hA1, 8'hB2, 8'hC3};

    always #5 clk = ~clk;

    fila_circular #(.WIDTH(8), .DEPTH(8)) dut8 (
        .clock_10khz(clk), .reset(rst_n), .clear_in(clr), .data_in(din),
        .enqueue_in(enq), .dequeue_in(deq), .data_out(d8), .data_valid_out(v8),
        .len_out(l8), .full_out(f8), .empty_out(e8), .overflow_out(o8), .underflow_out(u8)
    );

    fila_circular #(.WIDTH(8), .DEPTH(5)) dut5 (
        .clock_10khz(clk), .reset(rst_n), .clear_in(clr), .data_in(din),
        .enqueue_in(enq), .dequeue_in(deq), .data_out(d5), .data_valid_out(v5),
        .len_out(l5), .full_out(f5), .empty_out(e5), .overflow_out(o5), .underflow_out(u5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic op(input logic c, input logic e, input logic d, input logic [7:0] x);
        clr = c; enq = e; deq = d; din = x;
        @(posedge clk); #1;
        clr = 1'b0; enq = 1'b0; deq = 1'b0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_len", 32'(l8), 0);
        chk("rst_empty", 32'(e8), 1);
        chk("rst_full", 32'(f8), 0);
        chk("rst_data", 32'(d8), 0);
        chk("rst_valid", 32'(v8), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        // basic enqueue then dequeue in order
        op(0, 1, 0, 8'hA1); op(0, 1, 0, 8'hB2); op(0, 1, 0, 8'hC3);
        chk("t1_len3", 32'(l8), 3);
        for (int i = 0; i < 3; i++) begin
            op(0, 0, 1, 8'h00);
            chk("t1_data", 32'(d8), 32'(t1[i]));
            chk("t1_valid", 32'(v8), 1);
            chk("t1_len", 32'(l8), 32'(2 - i));
        end
        chk("t1_empty", 32'(e8), 1);
        op(0, 0, 0, 8'h00);
        chk("t1_valid_drop", 32'(v8), 0);
        chk("t1_data_hold", 32'(d8), 'hC3);
        // fill to full, then overflow
        for (int i = 0; i < 8; i++) op(0, 1, 0, 8'(8'h10 + i));
        chk("t2_full", 32'(f8), 1);
        chk("t2_len8", 32'(l8), 8);
        op(0, 1, 0, 8'h99);
        chk("t2_ovf", 32'(o8), 1);
        chk("t2_len_hold", 32'(l8), 8);
        op(0, 0, 0, 8'h00);
        chk("t2_ovf_drop", 32'(o8), 0);
        // full with simultaneous enqueue and dequeue
        op(0, 1, 1, 8'h55);
        chk("t3_data", 32'(d8), 'h10);
        chk("t3_len", 32'(l8), 8);
        chk("t3_no_ovf", 32'(o8), 0);
        chk("t3_valid", 32'(v8), 1);
        for (int i = 1; i < 8; i++) begin
            op(0, 0, 1, 8'h00);
            chk("t3_order", 32'(d8), 32'(8'h10 + i));
        end
        op(0, 0, 1, 8'h00);
        chk("t3_wrap55", 32'(d8), 'h55);
        chk("t3_empty", 32'(e8), 1);
        // empty with simultaneous enqueue and dequeue
        op(0, 1, 1, 8'h77);
        chk("t4_unf", 32'(u8), 1);
        chk("t4_len1", 32'(l8), 1);
        chk("t4_no_valid", 32'(v8), 0);
        chk("t4_data_hold", 32'(d8), 'h55);
        op(0, 0, 1, 8'h00);
        chk("t4_data77", 32'(d8), 'h77);
        chk("t4_unf_drop", 32'(u8), 0);
        chk("t4_empty", 32'(e8), 1);
        // clear has priority over enqueue and dequeue
        for (int i = 0; i < 4; i++) op(0, 1, 0, 8'(8'h30 + i));
        chk("t6_len4", 32'(l8), 4);
        op(1, 1, 1, 8'hEE);
        chk("t6_len0", 32'(l8), 0);
        chk("t6_empty", 32'(e8), 1);
        chk("t6_no_valid", 32'(v8), 0);
        chk("t6_no_ovf", 32'(o8), 0);
        chk("t6_no_unf", 32'(u8), 0);
        chk("t6_data_hold", 32'(d8), 'h77);
        op(0, 0, 1, 8'h00);
        chk("t6_unf_after_clr", 32'(u8), 1);
        // asynchronous reset mid-burst
        op(0, 1, 0, 8'h40); op(0, 1, 0, 8'h41); op(0, 1, 0, 8'h42);
        op(0, 0, 1, 8'h00);
        chk("t6_pre_rst_data", 32'(d8), 'h40);
        enq = 1'b1; din = 8'h43;
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("mrst_len", 32'(l8), 0);
        chk("mrst_data", 32'(d8), 0);
        chk("mrst_valid", 32'(v8), 0);
        chk("mrst_empty", 32'(e8), 1);
        chk("mrst_len5", 32'(l5), 0);
        @(posedge clk); #1 rst_n = 1'b1; enq = 1'b0;
        // DEPTH=5 wrap with enqueue/dequeue pairs
        op(0, 1, 0, 8'h20); op(0, 1, 0, 8'h21);
        for (int k = 0; k < 12; k++) begin
            op(0, 1, 1, 8'(8'h22 + k));
            chk("t5_order", 32'(d5), 32'(8'h20 + k));
            chk("t5_len", 32'(l5), 2);
        end
        op(0, 1, 0, 8'hA0); op(0, 1, 0, 8'hA1); op(0, 1, 0, 8'hA2);
        chk("t5_len5", 32'(l5), 5);
        chk("t5_full", 32'(f5), 1);
        op(0, 0, 1, 8'h00);
        chk("t5_after_fill", 32'(d5), 'h2C);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
